param_counter_bank: RTL and testbench
=====================================

// Module: param_counter_bank
// PURPOSE
//  Bank of CHANNELS independent WIDTH-bit counters with per-channel enable, direction and parallel load.
//  A shared programmable modulo limit applies to all channels, and a global wrap/saturate mode selects
//  behaviour at the limits. Each channel raises a registered terminal-count pulse at its boundary.
//  Reset is asserted asynchronously and released through an internal synchronizer, so all counts read 0
//  from simulation time zero. Used wherever event/timer counting is needed: perf counters, timeouts, dividers.
// PARAMETERS
//  WIDTH        16  bits per counter channel (>=2)
//  CHANNELS     4   number of independent counters (>=1)
//  SYNC_STAGES  2   reset-release synchronizer depth (>=2)
// PORTS
//  clock     in   1                 rising-edge clock
//  resetN    in   1                 reset, asynchronous, active-low
//  clear     in   1                 synchronous clear of all channels
//  en        in   CHANNELS          per-channel count enable
//  up        in   CHANNELS          per-channel direction: 1=increment, 0=decrement
//  load      in   CHANNELS          per-channel parallel load strobe
//  load_val  in   CHANNELS*WIDTH    load values; channel i at [i*WIDTH +: WIDTH]
//  modulo    in   WIDTH             shared upper limit; count range is 0..modulo
//  sat_mode  in   1                 0=wrap at limits, 1=saturate (hold) at limits
//  count     out  CHANNELS*WIDTH    counter values; channel i at [i*WIDTH +: WIDTH]
//  tc        out  CHANNELS          terminal-count pulse, one cycle per boundary step
//  ready     out  1                 1 once the reset synchronizer has released
// BEHAVIOUR
//  - resetN=0: count=0, tc=0, ready=0 immediately (async), including at t=0 before any clock edge.
//  - Reset release: synchronizer shift register clears asynchronously and fills with 1s on clock edges.
//    ready rises on the SYNC_STAGES-th rising edge after resetN goes high.
//    en/load/clear are ignored while ready=0.
//  - Per channel, priority per edge (ready=1): clear > load[i] > en[i] > hold.
//  - clear: count=0, tc=0 on all channels next edge.
//  - load[i]: count_i=load_val_i exactly, even if > modulo; tc_i=0.
//  - en[i], up=1, count_i < modulo: count_i+1; tc_i=0.
//  - en[i], up=1, count_i >= modulo: tc_i=1.
//    Next count_i = 0 when sat_mode=0, or held when sat_mode=1.
//  - en[i], up=0, count_i != 0: count_i-1; tc_i=0.
//    If the loaded count is > modulo, down-counting decrements normally.
//  - en[i], up=0, count_i == 0: tc_i=1.
//    Next count_i = modulo when sat_mode=0, or held (0) when sat_mode=1.
//  - tc_i is registered and high exactly the cycle after a boundary step.
//    In saturate mode it repeats every enabled cycle while held at the limit.
//  - en[i]=0 and no load/clear: count_i held, tc_i=0.
//  - modulo=0: counter pinned at 0; every enabled step is a boundary step (tc_i=1).
//  - modulo changes take effect on the next edge and are compared against the current count.
//  - Arithmetic is unsigned WIDTH-bit; the internal +/-1 never overflows the stored range.
//  - Channels are fully independent apart from shared modulo, sat_mode and clear.
//  - resetN low mid-operation: immediate return to reset values; ready drops to 0.
//  - Latency: every count/tc change is visible one clock after the causing inputs.
// TESTING
//  1. resetN=0 at t=0, released at t=2ns, clock period 20ns.
//     -> count==0 at t=3ns, before any edge; ready=1 after 2 rising edges; no count while ready=0.
//  2. WIDTH=16, modulo=5, sat_mode=0, ch0 en=1 up=1 for 8 cycles.
//     -> count 1,2,3,4,5,0,1,2; tc0 high only the cycle count reads 0.
//  3. sat_mode=1, modulo=5, ch1 down from 2 for 4 cycles.
//     -> count 1,0,0,0; tc1 high for both held cycles.
//  4. Same edge: ch2 load=1 load_val=0x00FF, en=1, clear=0.
//     -> count2=0x00FF (load wins).
//     Same edge with clear=1 -> count2=0 (clear wins).
//  5. modulo=0xFFFF, ch3 loaded 0xFFFE, up, wrap, 3 enabled cycles.
//     -> 0xFFFF, 0x0000 with tc3=1, 0x0001.
//  6. resetN pulsed low mid-count (async, between edges).
//     -> count=0, tc=0, ready=0 immediately; counting resumes only after resynchronization.

Source files
------------

// File: rtl/param_counter_bank_if.sv
// Bus bundle for param_counter_bank: control strobes, shared limit/mode, and the count/tc/ready outputs.
// The master modport drives the controls; the slave modport is the counter bank side.
interface param_counter_bank_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  logic                        clear;
  logic [CHANNELS-1:0]         en;
  logic [CHANNELS-1:0]         up;
  logic [CHANNELS-1:0]         load;
  logic [CHANNELS*WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]            modulo;
  logic                        sat_mode;
  logic [CHANNELS*WIDTH-1:0]   count;
  logic [CHANNELS-1:0]         tc;
  logic                        ready;

  modport master (
    output clear, en, up, load, load_val, modulo, sat_mode,
    input  count, tc, ready
  );

  modport slave (
    input  clear, en, up, load, load_val, modulo, sat_mode,
    output count, tc, ready
  );
endinterface

// File: rtl/param_counter_bank.sv
// Bank of independent up/down counters sharing one modulo limit and one wrap/saturate mode.
// Each channel pulses tc for one cycle after every boundary step.
module param_counter_bank #(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  resetN,
  param_counter_bank_if.slave   bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ready;
  logic [WIDTH-1:0]       cnt_q [CHANNELS];
  logic [CHANNELS-1:0]    tc_q;

  // Reset asserts asynchronously but releases only after the shift register fills with 1s.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign ready = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      tc_q <= '0;
    end else if (!ready) begin
      tc_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        tc_q[i] <= 1'b0;
        if (bus.clear) begin
          cnt_q[i] <= '0;
        end else if (bus.load[i]) begin
          cnt_q[i] <= bus.load_val[i*WIDTH +: WIDTH];
        end else if (bus.en[i]) begin
          if (bus.up[i]) begin
            // >= rather than == so a count loaded above the limit still hits the boundary.
            if (cnt_q[i] >= bus.modulo) begin
              tc_q[i] <= 1'b1;
              if (!bus.sat_mode) begin
                cnt_q[i] <= '0;
              end
            end else begin
              cnt_q[i] <= cnt_q[i] + ONE;
            end
          end else begin
            if (cnt_q[i] == '0) begin
              tc_q[i] <= 1'b1;
              if (!bus.sat_mode) begin
                cnt_q[i] <= bus.modulo;
              end
            end else begin
              cnt_q[i] <= cnt_q[i] - ONE;
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_count_out
    assign bus.count[g*WIDTH +: WIDTH] = cnt_q[g];
  end

  assign bus.tc    = tc_q;
  assign bus.ready = ready;

endmodule

// File: tb/tb_param_counter_bank.sv
// Directed plus randomized bench for param_counter_bank, checked against an arithmetic reference model.
module tb_param_counter_bank;
  localparam int W  = 16;
  localparam int CH = 4;
  localparam int SS = 2;

  logic clock  = 1'b0;
  logic resetN = 1'b0;

  param_counter_bank_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  param_counter_bank #(.WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(SS)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  always #10 clock = ~clock;

  int unsigned mc [CH];
  bit          mt [CH];
  int          rel;
  int          nchk;
  int          nfail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one clock edge computed from the currently applied inputs.
  task automatic model_edge();
    int unsigned m;
    int unsigned lim;
    bit rdy;
    if (!resetN) return;
    rdy = (rel >= SS);
    lim = 32'(bus.modulo);
    for (int i = 0; i < CH; i++) begin
      m = mc[i];
      mt[i] = 1'b0;
      if (!rdy) begin
        // inputs ignored until resynchronized
      end else if (bus.clear) begin
        m = 0;
      end else if (bus.load[i]) begin
        m = 32'(bus.load_val[i*W +: W]);
      end else if (bus.en[i]) begin
        if (bus.up[i]) begin
          if (m >= lim) begin
            mt[i] = 1'b1;
            m = bus.sat_mode ? m : 0;
          end else begin
            m = m + 1;
          end
        end else if (m == 0) begin
          mt[i] = 1'b1;
          m = bus.sat_mode ? 0 : lim;
        end else begin
          m = m - 1;
        end
      end
      mc[i] = m;
    end
    if (rel < SS) rel++;
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < CH; i++) begin
      check($sformatf("%s_count%0d", tag, i), 32'(bus.count[i*W +: W]), mc[i]);
      check($sformatf("%s_tc%0d", tag, i), 32'(bus.tc[i]), 32'(mt[i]));
    end
    check({tag, "_ready"}, 32'(bus.ready), (rel >= SS) ? 32'd1 : 32'd0);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    compare_all(tag);
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      mc[i] = 0;
      mt[i] = 1'b0;
    end
    rel = 0;
  endtask

  int unsigned exp2 [8] = '{1, 2, 3, 4, 5, 0, 1, 2};
  int unsigned exp3 [4] = '{1, 0, 0, 0};
  bit          tc3  [4] = '{0, 0, 1, 1};
  int unsigned exp5 [3] = '{32'hFFFF, 0, 1};
  bit          tc5  [3] = '{0, 1, 0};

  initial begin
    nchk  = 0;
    nfail = 0;
    model_reset();
    bus.clear    = 1'b0;
    bus.en       = '0;
    bus.up       = '0;
    bus.load     = '0;
    bus.load_val = '0;
    bus.modulo   = 16'd5;
    bus.sat_mode = 1'b0;

    // reset at time zero, release at 2ns, check before any edge
    #2 resetN = 1'b1;
    #1;
    compare_all("t3ns");
    bus.en = '1;
    bus.up = '1;
    step("sync1");
    step("sync2");
    check("ready_after_2", 32'(bus.ready), 32'd1);

    // wrap up-count on ch0 with modulo 5
    bus.en = 4'b0001;
    bus.up = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      step("wrap_up");
      check("wrap_seq", 32'(bus.count[0 +: W]), exp2[k]);
      check("wrap_tc", 32'(bus.tc[0]), (exp2[k] == 0) ? 32'd1 : 32'd0);
    end

    // saturating down-count on ch1 from 2
    bus.en           = '0;
    bus.sat_mode     = 1'b1;
    bus.load         = 4'b0010;
    bus.load_val[W +: W] = 16'd2;
    step("sat_load");
    bus.load = '0;
    bus.en   = 4'b0010;
    bus.up   = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      step("sat_down");
      check("sat_seq", 32'(bus.count[W +: W]), exp3[k]);
      check("sat_tc", 32'(bus.tc[1]), 32'(tc3[k]));
    end

    // priority: load over enable, clear over load
    bus.en   = 4'b0100;
    bus.up   = 4'b0100;
    bus.load = 4'b0100;
    bus.load_val[2*W +: W] = 16'h00FF;
    step("load_wins");
    check("load_wins_val", 32'(bus.count[2*W +: W]), 32'h00FF);
    bus.clear = 1'b1;
    step("clear_wins");
    check("clear_wins_val", 32'(bus.count[2*W +: W]), 32'h0);
    bus.clear = 1'b0;
    bus.load  = '0;
    bus.en    = '0;

    // full-range wrap on ch3
    bus.modulo   = 16'hFFFF;
    bus.sat_mode = 1'b0;
    bus.load     = 4'b1000;
    bus.load_val[3*W +: W] = 16'hFFFE;
    step("full_load");
    bus.load = '0;
    bus.en   = 4'b1000;
    bus.up   = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      step("full_wrap");
      check("full_seq", 32'(bus.count[3*W +: W]), exp5[k]);
      check("full_tc", 32'(bus.tc[3]), 32'(tc5[k]));
    end

    // randomized traffic, including modulo 0 and loads above the limit
    for (int k = 0; k < 400; k++) begin
      bus.en       = 4'($urandom);
      bus.up       = 4'($urandom);
      bus.load     = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
      bus.load_val = 64'({$urandom, $urandom});
      if ($urandom_range(0, 3) != 0) begin
        for (int i = 0; i < CH; i++) bus.load_val[i*W +: W] = 16'($urandom_range(0, 9));
      end
      bus.clear    = ($urandom_range(0, 40) == 0);
      bus.sat_mode = ($urandom_range(0, 20) == 0) ? ~bus.sat_mode : bus.sat_mode;
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.modulo = 16'd0;
          1: bus.modulo = 16'd1;
          2: bus.modulo = 16'($urandom_range(2, 12));
          default: bus.modulo = 16'($urandom);
        endcase
      end
      step("rand");
    end

    // asynchronous reset between edges
    bus.en    = '1;
    bus.up    = '1;
    bus.load  = '0;
    bus.clear = 1'b0;
    bus.modulo = 16'd7;
    step("pre_rst");
    #5 resetN = 1'b0;
    model_reset();
    #1;
    compare_all("async_rst");
    #2 resetN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step("resync");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
